// File: rtl/prog_counter_pkg.sv
// Shared types and mode encodings for the programmable counter and its users.
package prog_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;
  localparam logic DIR_UP        = 1'b0;
  localparam logic DIR_DOWN      = 1'b1;

endpackage

// File: rtl/tick_prescaler.sv
// Clock-enable divider: while enabled, tick fires every divisor+1 cycles.
// The phase freezes when enable is low, so a paused client resumes in phase.
module tick_prescaler #(
  parameter int PRE_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [PRE_W-1:0] divisor,
  output logic             tick
);

  logic [PRE_W-1:0] cnt_q;

  assign tick = enable && (cnt_q == divisor);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= tick ? '0 : cnt_q + PRE_W'(1);
    end
  end

endmodule

// File: rtl/prog_counter.sv
// Programmable up/down counter with prescaler, one-shot or auto-reload mode,
// pause/resume, abort, terminal-count pulse and a saturating reload counter.
module prog_counter
  import prog_counter_pkg::*;
#(
  parameter int WIDTH  = 17,
  parameter int PRE_W  = 8,
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              pause,
  input  logic [WIDTH-1:0]  limit,
  input  logic [PRE_W-1:0]  prescale,
  input  logic              periodic,
  input  logic              down,
  output logic              counting,
  output logic              paused,
  output logic              done,
  output logic [WIDTH-1:0]  count,
  output logic [WRAP_W-1:0] wraps
);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   count_q, count_d;
  logic [WRAP_W-1:0]  wraps_q, wraps_d;
  logic               done_d;
  logic [WIDTH-1:0]   limit_q, limit_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic               per_q, per_d;
  logic               down_q, down_d;

  logic pre_en, pre_clr, tick;
  logic terminal;
  logic [WIDTH-1:0] reload_val;

  // Prescaler only advances in an active cycle that no control pulse overrides.
  assign pre_en  = (state_q != ST_IDLE) && !pause && !abort && !start;
  assign pre_clr = abort || start;

  tick_prescaler #(.PRE_W(PRE_W)) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .clear   (pre_clr),
    .enable  (pre_en),
    .divisor (pre_q),
    .tick    (tick)
  );

  assign terminal   = (down_q == DIR_DOWN) ? (count_q == '0) : (count_q == limit_q);
  assign reload_val = (down_q == DIR_DOWN) ? limit_q : '0;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    wraps_d = wraps_q;
    done_d  = 1'b0;
    limit_d = limit_q;
    pre_d   = pre_q;
    per_d   = per_q;
    down_d  = down_q;

    if (abort) begin
      state_d = ST_IDLE;
      count_d = '0;
    end else if (start) begin
      limit_d = limit;
      pre_d   = prescale;
      per_d   = periodic;
      down_d  = down;
      count_d = (down == DIR_DOWN) ? limit : '0;
      wraps_d = '0;
      state_d = ST_RUN;
    end else if (state_q != ST_IDLE) begin
      if (pause) begin
        state_d = ST_PAUSED;
      end else begin
        // A PAUSED cycle with pause low already behaves as RUN, so resume costs no cycle.
        state_d = ST_RUN;
        if (tick) begin
          if (terminal) begin
            done_d = 1'b1;
            if (per_q == MODE_PERIODIC) begin
              count_d = reload_val;
              if (wraps_q != '1) wraps_d = wraps_q + WRAP_W'(1);
            end else begin
              count_d = '0;
              state_d = ST_IDLE;
            end
          end else begin
            count_d = (down_q == DIR_DOWN) ? count_q - WIDTH'(1) : count_q + WIDTH'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      wraps_q  <= '0;
      done     <= 1'b0;
      counting <= 1'b0;
      paused   <= 1'b0;
      limit_q  <= '0;
      pre_q    <= '0;
      per_q    <= MODE_ONESHOT;
      down_q   <= DIR_UP;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      wraps_q  <= wraps_d;
      done     <= done_d;
      counting <= (state_d != ST_IDLE);
      paused   <= (state_d == ST_PAUSED);
      limit_q  <= limit_d;
      pre_q    <= pre_d;
      per_q    <= per_d;
      down_q   <= down_d;
    end
  end

  assign count = count_q;
  assign wraps = wraps_q;

endmodule

// File: tb/tb_prog_counter.sv
// Bench for prog_counter: directed scenarios plus random control traffic,
// every cycle scored against a position/phase based reference model.
module tb_prog_counter;

  localparam int WIDTH  = 17;
  localparam int PRE_W  = 8;
  localparam int WRAP_W = 8;
  localparam int EW     = 3 + WIDTH + WRAP_W;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              pause = 1'b0;
  logic [WIDTH-1:0]  limit = '0;
  logic [PRE_W-1:0]  prescale = '0;
  logic              periodic = 1'b0;
  logic              down = 1'b0;
  logic              counting, paused, done;
  logic [WIDTH-1:0]  count;
  logic [WRAP_W-1:0] wraps;

  int n_checks = 0;
  int n_pass   = 0;

  logic [EW-1:0] exp_q[$];

  // reference model state: run flag, position along the sequence, active-cycle phase
  int unsigned m_run, m_paused, m_done, m_pos, m_wraps, m_active;
  int unsigned l_limit, l_pre, l_per, l_down;

  prog_counter #(.WIDTH(WIDTH), .PRE_W(PRE_W), .WRAP_W(WRAP_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .pause    (pause),
    .limit    (limit),
    .prescale (prescale),
    .periodic (periodic),
    .down     (down),
    .counting (counting),
    .paused   (paused),
    .done     (done),
    .count    (count),
    .wraps    (wraps)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v)
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp_v, $time);
    else
      n_pass++;
  endtask

  task automatic model_step();
    if (reset) begin
      m_run = 0; m_paused = 0; m_done = 0; m_pos = 0; m_wraps = 0; m_active = 0;
      l_limit = 0; l_pre = 0; l_per = 0; l_down = 0;
    end else if (abort) begin
      m_run = 0; m_paused = 0; m_done = 0; m_pos = 0;
    end else if (start) begin
      l_limit = limit; l_pre = prescale; l_per = periodic; l_down = down;
      m_run = 1; m_paused = 0; m_done = 0; m_pos = 0; m_wraps = 0; m_active = 0;
    end else if (m_run != 0) begin
      m_done = 0;
      if (pause) begin
        m_paused = 1;
      end else begin
        m_paused = 0;
        if ((m_active % (l_pre + 1)) == l_pre) begin
          if (m_pos == l_limit) begin
            m_done = 1;
            m_pos  = 0;
            if (l_per != 0) begin
              if (m_wraps < 255) m_wraps++;
            end else begin
              m_run = 0;
            end
          end else begin
            m_pos++;
          end
        end
        m_active++;
      end
    end else begin
      m_done = 0;
    end
  endtask

  function automatic logic [EW-1:0] model_outputs();
    int unsigned c;
    c = (m_run == 0) ? 0 : ((l_down != 0) ? l_limit - m_pos : m_pos);
    return {m_run[0], m_paused[0], m_done[0], c[WIDTH-1:0], m_wraps[WRAP_W-1:0]};
  endfunction

  // one clock: model predicts the edge, DUT sampled 1 time unit later
  task automatic step();
    logic [EW-1:0] e;
    @(posedge clk);
    model_step();
    exp_q.push_back(model_outputs());
    #1;
    e = exp_q.pop_front();
    check("counting", 32'(counting), 32'(e[EW-1]));
    check("paused",   32'(paused),   32'(e[EW-2]));
    check("done",     32'(done),     32'(e[EW-3]));
    check("count",    32'(count),    32'(e[WIDTH+WRAP_W-1:WRAP_W]));
    check("wraps",    32'(wraps),    32'(e[WRAP_W-1:0]));
  endtask

  task automatic do_start(input int unsigned lim, input int unsigned pre,
                          input bit per, input bit dn);
    limit = WIDTH'(lim); prescale = PRE_W'(pre); periodic = per; down = dn;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) step();
    check("reset_count", 32'(count), 0);
    check("reset_counting", 32'(counting), 0);
    reset = 1'b0;
    step();

    // one-shot up to 5
    do_start(5, 0, 1'b0, 1'b0);
    repeat (5) step();
    check("up5_count5", 32'(count), 5);
    step();
    check("up5_done", 32'(done), 1);
    check("up5_idle", 32'(counting), 0);
    repeat (2) step();

    // periodic down from 3, prescale 2
    do_start(3, 2, 1'b1, 1'b1);
    repeat (26) step();
    pulse_abort();
    check("abort_wraps_held", 32'(wraps), 2);
    check("abort_count", 32'(count), 0);
    step();

    // pause for 4 cycles at count 4
    do_start(10, 0, 1'b0, 1'b0);
    repeat (4) step();
    pause = 1'b1;
    repeat (4) step();
    check("pause_hold", 32'(count), 4);
    pause = 1'b0;
    step();
    check("resume_next", 32'(count), 5);
    repeat (10) step();

    // restart mid-count with a smaller limit
    do_start(20, 0, 1'b0, 1'b0);
    repeat (7) step();
    do_start(2, 0, 1'b0, 1'b0);
    check("restart_zero", 32'(count), 0);
    repeat (4) step();

    // limit 0 periodic: done every tick, wraps saturates
    do_start(0, 0, 1'b1, 1'b0);
    repeat (300) step();
    check("wraps_sat", 32'(wraps), 255);
    check("lim0_done", 32'(done), 1);
    pulse_abort();

    // reset mid-run, then start and abort together
    do_start(20, 0, 1'b0, 1'b0);
    repeat (9) step();
    reset = 1'b1;
    step();
    check("midreset_count", 32'(count), 0);
    reset = 1'b0;
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    check("start_abort_idle", 32'(counting), 0);
    step();

    // random control traffic; config inputs churn every cycle
    for (int i = 0; i < 4000; i++) begin
      limit    = ($urandom_range(0, 9) == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 9));
      prescale = PRE_W'($urandom_range(0, 3));
      periodic = 1'($urandom);
      down     = 1'($urandom);
      start    = ($urandom_range(0, 39) == 0);
      abort    = ($urandom_range(0, 99) == 0);
      reset    = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 7) == 0) pause = ~pause;
      step();
    end
    start = 1'b0; abort = 1'b0; reset = 1'b0; pause = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
